// File: rtl/alu_shift_pkg.sv
// Shared definitions for the multi-cycle shift/rotate unit: opcodes, FSM states, default widths.
package alu_shift_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_SHAMT_W = 5;

  localparam logic [2:0] OP_SLA = 3'b000;
  localparam logic [2:0] OP_SRA = 3'b001;
  localparam logic [2:0] OP_SLL = 3'b010;
  localparam logic [2:0] OP_SRL = 3'b011;
  localparam logic [2:0] OP_ROL = 3'b100;
  localparam logic [2:0] OP_ROR = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic op_legal(input logic [2:0] op);
    return (op <= OP_ROR);
  endfunction

endpackage

// File: rtl/alu_shift_step.sv
// Combinational single step (1 or 4 bit positions) of the shift working register,
// plus the SLA overflow contribution of that step.
module alu_shift_step
  import alu_shift_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] w,
  input  logic [2:0]       opcode,
  input  logic             sign,
  input  logic             quad,
  output logic [WIDTH-1:0] nxt,
  output logic             ovf
);

  logic signed [WIDTH-1:0] ws;
  logic signed [WIDTH-1:0] sra1;
  logic signed [WIDTH-1:0] sra4;

  assign ws   = w;
  assign sra1 = ws >>> 1;
  assign sra4 = ws >>> 4;

  always_comb begin
    nxt = w;
    ovf = 1'b0;
    case (opcode)
      OP_SLA, OP_SLL: nxt = quad ? (w << 4) : (w << 1);
      OP_SRA:         nxt = quad ? $unsigned(sra4) : $unsigned(sra1);
      OP_SRL:         nxt = quad ? (w >> 4) : (w >> 1);
      OP_ROL:         nxt = quad ? {w[WIDTH-5:0], w[WIDTH-1:WIDTH-4]} : {w[WIDTH-2:0], w[WIDTH-1]};
      OP_ROR:         nxt = quad ? {w[3:0], w[WIDTH-1:4]} : {w[0], w[WIDTH-1:1]};
      default:        nxt = '0;
    endcase
    // Every bit that becomes the new MSB during this step must match the original sign.
    if (opcode == OP_SLA) begin
      ovf = quad ? (w[WIDTH-2:WIDTH-5] != {4{sign}}) : (w[WIDTH-2] != sign);
    end
  end

endmodule

// File: rtl/alu_shift_seq.sv
// Multi-cycle shift/rotate execution unit with valid/ready request and response channels.
// Optional build macro ALU_SHIFT_MULTISTEP_EN: step 4 bits per cycle while cnt >= 4.
module alu_shift_seq
  import alu_shift_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SHAMT_W = DEF_SHAMT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [2:0]       req_opcode,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_c,
  output logic             rsp_zero,
  output logic             rsp_neg,
  output logic             rsp_overflow,
  output logic             rsp_err
);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic               sign_q, sign_d;
  logic               ovf_q, ovf_d;
  logic [WIDTH-1:0]   c_q, c_d;
  logic               zero_q, zero_d;
  logic               neg_q, neg_d;
  logic               err_q, err_d;

  logic               quad;
  logic [SHAMT_W-1:0] step_amt;
  logic [SHAMT_W-1:0] cnt_nxt;
  logic [WIDTH-1:0]   step_nxt;
  logic               step_ovf;
  logic               unused_b;

  assign unused_b = ^req_b[WIDTH-1:SHAMT_W];

`ifdef ALU_SHIFT_MULTISTEP_EN
  assign quad = (cnt_q >= SHAMT_W'(4));
`else
  assign quad = 1'b0;
`endif

  assign step_amt = quad ? SHAMT_W'(4) : SHAMT_W'(1);
  assign cnt_nxt  = cnt_q - step_amt;

  alu_shift_step #(.WIDTH(WIDTH)) u_step (
    .w      (work_q),
    .opcode (op_q),
    .sign   (sign_q),
    .quad   (quad),
    .nxt    (step_nxt),
    .ovf    (step_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      sign_q  <= 1'b0;
      ovf_q   <= 1'b0;
      c_q     <= '0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      sign_q  <= sign_d;
      ovf_q   <= ovf_d;
      c_q     <= c_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    sign_d  = sign_q;
    ovf_d   = ovf_q;
    c_d     = c_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d   = req_opcode;
          work_d = req_a;
          sign_d = req_a[WIDTH-1];
          cnt_d  = req_b[SHAMT_W-1:0];
          ovf_d  = 1'b0;
          err_d  = 1'b0;
          if (!op_legal(req_opcode)) begin
            state_d = DONE;
            c_d     = '0;
            err_d   = 1'b1;
          end else if (req_b[SHAMT_W-1:0] == '0) begin
            state_d = DONE;
            c_d     = req_a;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        work_d = step_nxt;
        cnt_d  = cnt_nxt;
        ovf_d  = ovf_q | step_ovf;
        if (cnt_nxt == '0) begin
          state_d = DONE;
          c_d     = step_nxt;
        end
      end
      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Flags are derived from the value being registered so they always track rsp_c.
    zero_d = (c_d == '0);
    neg_d  = c_d[WIDTH-1];
  end

  assign req_ready    = (state_q == IDLE);
  assign rsp_valid    = (state_q == DONE);
  assign rsp_c        = c_q;
  assign rsp_zero     = zero_q;
  assign rsp_neg      = neg_q;
  assign rsp_overflow = ovf_q;
  assign rsp_err      = err_q;

endmodule

// File: tb/tb_alu_shift_seq.sv
// Scoreboard bench for alu_shift_seq; expected results come from a whole-shift reference model.
module tb_alu_shift_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [2:0]  req_opcode;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_c;
  logic        rsp_zero;
  logic        rsp_neg;
  logic        rsp_overflow;
  logic        rsp_err;

  always #5 clk = ~clk;

  alu_shift_seq dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_opcode   (req_opcode),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_c        (rsp_c),
    .rsp_zero     (rsp_zero),
    .rsp_neg      (rsp_neg),
    .rsp_overflow (rsp_overflow),
    .rsp_err      (rsp_err)
  );

  typedef struct {
    logic [31:0] c;
    logic        zero;
    logic        neg;
    logic        ovf;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    exp_t e;
    int   s;
    s     = int'(b[4:0]);
    e.c   = '0;
    e.ovf = 1'b0;
    e.err = 1'b0;
    case (op)
      3'b000, 3'b010: e.c = a << s;
      3'b001:         e.c = $unsigned($signed(a) >>> s);
      3'b011:         e.c = a >> s;
      3'b100:         e.c = (s == 0) ? a : ((a << s) | (a >> (32 - s)));
      3'b101:         e.c = (s == 0) ? a : ((a >> s) | (a << (32 - s)));
      default:        e.err = 1'b1;
    endcase
    if (op == 3'b000) begin
      for (int i = 0; i <= s; i++) begin
        if (a[31-i] != a[31]) e.ovf = 1'b1;
      end
    end
    e.zero = (e.c == 32'd0);
    e.neg  = e.c[31];
    if (e.err) e.lat = 1;
`ifdef ALU_SHIFT_MULTISTEP_EN
    else e.lat = s / 4 + s % 4 + 1;
`else
    else e.lat = s + 1;
`endif
    return e;
  endfunction

  // Called 1 time unit after a rising edge with the DUT idle.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op, input int hold);
    exp_t e;
    int   lat;
    sb.push_back(model(a, b, op));
    req_a      = a;
    req_b      = b;
    req_opcode = op;
    req_valid  = 1'b1;
    rsp_ready  = (hold == 0);
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    lat        = 1;
    req_valid  = 1'b0;
    req_a      = ~a;
    req_b      = 32'h3;
    req_opcode = 3'b101;
    while (!rsp_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    e = sb.pop_front();
    chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("latency", 32'(lat), 32'(e.lat));
    chk("rsp_c", rsp_c, e.c);
    chk("flags", {28'd0, rsp_zero, rsp_neg, rsp_overflow, rsp_err}, {28'd0, e.zero, e.neg, e.ovf, e.err});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
      chk("hold_c", rsp_c, e.c);
      chk("hold_flags", {28'd0, rsp_zero, rsp_neg, rsp_overflow, rsp_err}, {28'd0, e.zero, e.neg, e.ovf, e.err});
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("release_valid", {31'd0, rsp_valid}, 32'd0);
    chk("release_req_ready", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_a      = '0;
    req_b      = '0;
    req_opcode = '0;
    rsp_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_c", rsp_c, 32'd0);
    chk("rst_flags", {28'd0, rsp_zero, rsp_neg, rsp_overflow, rsp_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    do_op(32'hDDDDDDDD, 32'd1,        3'b000, 0);
    do_op(32'h40404040, 32'd1,        3'b000, 0);
    do_op(32'hFDFDFDFD, 32'd4,        3'b001, 0);
    do_op(32'h39393939, 32'd4,        3'b001, 0);
    do_op(32'h80000000, 32'd31,       3'b011, 0);
    do_op(32'h00000001, 32'd1,        3'b101, 0);
    do_op(32'h12345678, 32'd0,        3'b100, 0);
    do_op(32'hABCD0123, 32'hFFFFFFE0, 3'b000, 0);
    do_op(32'h13579BDF, 32'd5,        3'b111, 5);
    do_op(32'h2468ACE0, 32'd9,        3'b110, 0);
    do_op(32'hF8000000, 32'd5,        3'b000, 0);
    do_op(32'hFC000000, 32'd5,        3'b000, 2);
    do_op(32'hF0F0F0F0, 32'd7,        3'b100, 0);
    do_op(32'h0000FFFF, 32'd13,       3'b010, 0);
    for (int k = 0; k < 10; k++) begin
      do_op($urandom, $urandom, 3'($urandom_range(0, 5)), k % 3);
    end

    // Abort a long SRA part-way through with an asynchronous reset.
    req_a      = 32'h80001234;
    req_b      = 32'd20;
    req_opcode = 3'b001;
    req_valid  = 1'b1;
    rsp_ready  = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_shift_busy", {31'd0, req_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
    chk("abort_rsp_c", rsp_c, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_op(32'hC0000001, 32'd3, 32'd0 + 3'b001, 0);
    do_op(32'h7FFFFFFF, 32'd2, 3'b000, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
